// File: rtl/rvfi_lockstep_cmp_if.sv
// RVFI retirement bundle for the lockstep comparator: core (dut_*) and reference (ref_*) sides.
// The harness drives through master; the comparator samples through slave.
interface rvfi_lockstep_cmp_if #(
  parameter int unsigned XLEN = 32
);
  logic            dut_valid;
  logic [63:0]     dut_order;
  logic [XLEN-1:0] dut_pc;
  logic [31:0]     dut_insn;
  logic [4:0]      dut_rd_addr;
  logic [XLEN-1:0] dut_rd_wdata;
  logic            dut_trap;

  logic            ref_valid;
  logic [63:0]     ref_order;
  logic [XLEN-1:0] ref_pc;
  logic [31:0]     ref_insn;
  logic [4:0]      ref_rd_addr;
  logic [XLEN-1:0] ref_rd_wdata;
  logic            ref_trap;

  modport master (
    output dut_valid, dut_order, dut_pc, dut_insn, dut_rd_addr, dut_rd_wdata, dut_trap,
    output ref_valid, ref_order, ref_pc, ref_insn, ref_rd_addr, ref_rd_wdata, ref_trap
  );

  modport slave (
    input dut_valid, dut_order, dut_pc, dut_insn, dut_rd_addr, dut_rd_wdata, dut_trap,
    input ref_valid, ref_order, ref_pc, ref_insn, ref_rd_addr, ref_rd_wdata, ref_trap
  );
endinterface

// File: rtl/rvfi_lockstep_cmp.sv
// Lockstep comparator: FIFOs core retirements, compares each against the reference retirement.
// Define LOCKSTEP_CMP_TIMEOUT_EN to build the reference-stall timeout (counter + IDLE/WAIT/STALLED FSM).
module rvfi_lockstep_cmp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  rvfi_lockstep_cmp_if.slave         rvfi,
  output logic                       mismatch,
  output logic [5:0]                 mismatch_field,
  output logic [63:0]                mismatch_order,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       timeout,
  output logic                       error,
  output logic [31:0]                match_count,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            trap;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        dut_e, cmp_e;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] pending_d;
  logic          empty, full, bypass, push, pop, cmp_en, cmp_bad;
  logic          overflow_set, underflow_set, timeout_set;
  logic [5:0]    diff;

  assign dut_e = '{order: rvfi.dut_order, pc: rvfi.dut_pc, insn: rvfi.dut_insn,
                   rd_addr: rvfi.dut_rd_addr, rd_wdata: rvfi.dut_rd_wdata, trap: rvfi.dut_trap};

  assign empty  = (pending == '0);
  assign full   = (pending == CW'(DEPTH));
  assign bypass = rvfi.dut_valid && rvfi.ref_valid && empty;
  // At full, a simultaneous pop frees the slot being overwritten; the read sees the old entry.
  assign push   = rvfi.dut_valid && !bypass && (!full || rvfi.ref_valid);
  assign pop    = rvfi.ref_valid && !empty;
  assign cmp_en = bypass || pop;

  assign overflow_set  = rvfi.dut_valid && full && !rvfi.ref_valid;
  assign underflow_set = rvfi.ref_valid && empty && !rvfi.dut_valid;

  always_comb begin
    cmp_e   = bypass ? dut_e : mem[rptr];
    diff    = '0;
    diff[0] = (cmp_e.order   != rvfi.ref_order);
    diff[1] = (cmp_e.pc      != rvfi.ref_pc);
    diff[2] = (cmp_e.insn    != rvfi.ref_insn);
    diff[3] = (cmp_e.rd_addr != rvfi.ref_rd_addr);
    diff[4] = (cmp_e.rd_addr != 5'd0) && (cmp_e.rd_wdata != rvfi.ref_rd_wdata);
    diff[5] = (cmp_e.trap    != rvfi.ref_trap);
    cmp_bad = cmp_en && (diff != '0);
  end

  always_comb begin
    pending_d = pending;
    case ({push, pop})
      2'b10:   pending_d = pending + 1'b1;
      2'b01:   pending_d = pending - 1'b1;
      default: pending_d = pending;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dut_e;
  end

`ifdef LOCKSTEP_CMP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, WAIT, STALLED} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] stall_q, stall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (rvfi.ref_valid || empty)       stall_d = '0;
    else if (stall_q != TW'(TIMEOUT))  stall_d = stall_q + 1'b1;
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = WAIT;
      WAIT:    if (pending_d == '0) state_d = IDLE;
               else if (stall_d == TW'(TIMEOUT)) state_d = STALLED;
      STALLED: state_d = STALLED;
      default: state_d = IDLE;
    endcase
    timeout_set = (state_d == STALLED);
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign timeout_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr           <= '0;
      rptr           <= '0;
      pending        <= '0;
      mismatch       <= 1'b0;
      mismatch_field <= '0;
      mismatch_order <= '0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
      timeout        <= 1'b0;
      error          <= 1'b0;
      match_count    <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      pending   <= pending_d;
      mismatch  <= cmp_bad;
      overflow  <= overflow  | overflow_set;
      underflow <= underflow | underflow_set;
      timeout   <= timeout   | timeout_set;
      error     <= error | cmp_bad | overflow_set | underflow_set | timeout_set;
      if (cmp_en) begin
        mismatch_field <= diff;
        if (cmp_bad) mismatch_order <= cmp_e.order;
        else if (match_count != '1) match_count <= match_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rvfi_lockstep_cmp.sv
// Directed bench for rvfi_lockstep_cmp (DEPTH 8, TIMEOUT 16); timeout expectations follow LOCKSTEP_CMP_TIMEOUT_EN.
module tb_rvfi_lockstep_cmp;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic        mismatch, overflow, underflow, timeout, error;
  logic [5:0]  mismatch_field;
  logic [63:0] mismatch_order;
  logic [31:0] match_count;
  logic [3:0]  pending;

  rvfi_lockstep_cmp_if #(.XLEN(32)) bus ();

  rvfi_lockstep_cmp #(.XLEN(32), .DEPTH(8), .TIMEOUT(16)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rvfi           (bus.slave),
    .mismatch       (mismatch),
    .mismatch_field (mismatch_field),
    .mismatch_order (mismatch_order),
    .overflow       (overflow),
    .underflow      (underflow),
    .timeout        (timeout),
    .error          (error),
    .match_count    (match_count),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dut_valid = 1'b0;
    bus.ref_valid = 1'b0;
  endtask

  // Retirement fields are derived from the order so both sides can be driven identically.
  task automatic set_dut(input logic [63:0] o);
    bus.dut_valid    = 1'b1;
    bus.dut_order    = o;
    bus.dut_pc       = 32'h1000 + {o[29:0], 2'b00};
    bus.dut_insn     = 32'h13 ^ {o[24:0], 7'h0};
    bus.dut_rd_addr  = o[4:0];
    bus.dut_rd_wdata = o[31:0] * 32'h11;
    bus.dut_trap     = 1'b0;
  endtask

  task automatic set_ref(input logic [63:0] o);
    bus.ref_valid    = 1'b1;
    bus.ref_order    = o;
    bus.ref_pc       = 32'h1000 + {o[29:0], 2'b00};
    bus.ref_insn     = 32'h13 ^ {o[24:0], 7'h0};
    bus.ref_rd_addr  = o[4:0];
    bus.ref_rd_wdata = o[31:0] * 32'h11;
    bus.ref_trap     = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mismatch"},  mismatch,       0);
    chk({tag, "_field"},     mismatch_field, 0);
    chk({tag, "_morder"},    mismatch_order, 0);
    chk({tag, "_overflow"},  overflow,       0);
    chk({tag, "_underflow"}, underflow,      0);
    chk({tag, "_timeout"},   timeout,        0);
    chk({tag, "_error"},     error,          0);
    chk({tag, "_matches"},   match_count,    0);
    chk({tag, "_pending"},   pending,        0);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    set_dut(0);
    set_ref(0);
    idle();
    repeat (2) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Three in-order retirements, reference lags by two cycles.
    for (int i = 1; i <= 3; i++) begin
      set_dut(64'(i));
      tick();
      chk($sformatf("fill_pending_%0d", i), pending, 64'(i));
      chk("fill_no_mismatch", mismatch, 0);
    end
    idle();
    repeat (2) tick();
    chk("lag_pending", pending, 3);
    for (int i = 1; i <= 3; i++) begin
      set_ref(64'(i));
      tick();
      chk($sformatf("drain_matches_%0d", i), match_count, 64'(i));
      chk($sformatf("drain_pending_%0d", i), pending, 64'(3 - i));
      chk("drain_no_mismatch", mismatch, 0);
    end
    idle();

    // rd_wdata differs with rd_addr nonzero.
    set_dut(5);
    bus.dut_rd_wdata = 32'h1234;
    tick();
    idle();
    set_ref(5);
    bus.ref_rd_wdata = 32'h1235;
    tick();
    idle();
    chk("wdata_mismatch", mismatch, 1);
    chk("wdata_field", mismatch_field, 6'b010000);
    chk("wdata_morder", mismatch_order, 5);
    chk("wdata_error", error, 1);
    chk("wdata_matches", match_count, 3);
    tick();
    chk("wdata_pulse_end", mismatch, 0);
    chk("wdata_field_hold", mismatch_field, 6'b010000);

    // rd_addr 0: write data is ignored.
    set_dut(6);
    bus.dut_rd_addr  = 5'd0;
    bus.dut_rd_wdata = 32'hAAAA;
    tick();
    idle();
    set_ref(6);
    bus.ref_rd_addr  = 5'd0;
    bus.ref_rd_wdata = 32'hBBBB;
    tick();
    idle();
    chk("x0_mismatch", mismatch, 0);
    chk("x0_matches", match_count, 4);
    chk("x0_field_clear", mismatch_field, 0);
    chk("x0_pending", pending, 0);

    // Nine pushes into DEPTH 8: the ninth (order 18) is dropped.
    for (int i = 10; i <= 17; i++) begin
      set_dut(64'(i));
      tick();
    end
    chk("full_pending", pending, 8);
    chk("full_no_overflow", overflow, 0);
    set_dut(18);
    tick();
    idle();
    chk("ovf_flag", overflow, 1);
    chk("ovf_pending", pending, 8);
    set_dut(19);
    set_ref(10);
    tick();
    idle();
    chk("full_pushpop_pending", pending, 8);
    chk("full_pushpop_matches", match_count, 5);
    chk("full_pushpop_mismatch", mismatch, 0);
    for (int i = 11; i <= 17; i++) begin
      set_ref(64'(i));
      tick();
    end
    chk("tail_pending", pending, 1);
    set_ref(19);
    tick();
    idle();
    chk("tail_no_mismatch", mismatch, 0);
    chk("tail_matches", match_count, 13);
    chk("tail_pending_0", pending, 0);

    // Underflow then bypass on empty FIFO.
    do_reset();
    chk("rst2_matches", match_count, 0);
    set_ref(20);
    tick();
    idle();
    chk("udf_flag", underflow, 1);
    chk("udf_matches", match_count, 0);
    chk("udf_error", error, 1);
    chk("udf_no_mismatch", mismatch, 0);
    set_dut(30);
    set_ref(30);
    tick();
    chk("byp_matches", match_count, 1);
    chk("byp_pending", pending, 0);
    chk("byp_no_mismatch", mismatch, 0);
    set_dut(31);
    set_ref(31);
    bus.dut_trap = 1'b1;
    tick();
    idle();
    chk("byp_trap_mismatch", mismatch, 1);
    chk("byp_trap_field", mismatch_field, 6'b100000);
    chk("byp_trap_morder", mismatch_order, 31);
    chk("byp_trap_pending", pending, 0);

    // Reference stall: one push, no reference retirement.
    do_reset();
    set_dut(40);
    tick();
    idle();
    chk("stall_pending", pending, 1);
    repeat (15) tick();
    chk("stall_before_limit", timeout, 0);
    chk("stall_before_err", error, 0);
    tick();
`ifdef LOCKSTEP_CMP_TIMEOUT_EN
    chk("stall_timeout", timeout, 1);
    chk("stall_error", error, 1);
`else
    chk("stall_timeout_absent", timeout, 0);
    chk("stall_error_absent", error, 0);
`endif
    // Mismatching compare in flight when reset hits mid-cycle.
    set_ref(99);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    idle();
    reset_n = 1'b1;
    tick();
    chk("post_rst_mismatch", mismatch, 0);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvfi_lockstep_cmp.md
# rvfi_lockstep_cmp

Lockstep comparator downstream of the ISS reference model in the verification harness. Buffers each core RVFI retirement in a FIFO. When the reference model retires the matching instruction on its RVFI output, pops the oldest entry and compares them field by field. Reports mismatches, FIFO overflow/underflow and a reference-model stall timeout as registered flags and counters for the scoreboard and the end-of-test summary.

## Interface
Parameters:
- XLEN, 32, register/PC width
- DEPTH, 8, core-retirement FIFO depth (power of two, ≥2)
- TIMEOUT, 1024, cycles the FIFO may stay non-empty with no reference retirement

Ports:
- clk  in  1  harness clock
- reset_n  in  1  asynchronous active-low reset
- dut_valid  in  1  core retirement valid
- dut_order  in  64  core retirement order
- dut_pc  in  XLEN  core PC
- dut_insn  in  32  core instruction word
- dut_rd_addr  in  5  core destination register
- dut_rd_wdata  in  XLEN  core rd write data
- dut_trap  in  1  core trap flag
- ref_valid, ref_order, ref_pc, ref_insn, ref_rd_addr, ref_rd_wdata, ref_trap  in  same widths as the dut_* ports  reference-model retirement
- mismatch  out  1  one-cycle pulse: compare failed
- mismatch_field  out  6  {trap, rd_wdata, rd_addr, insn, pc, order}; bit set = differs
- mismatch_order  out  64  dut_order of the failing compare
- overflow  out  1  sticky: dut retirement dropped because FIFO full
- underflow  out  1  sticky: ref retirement with nothing to compare
- timeout  out  1  sticky: stall limit reached
- error  out  1  sticky OR of all error conditions
- match_count  out  32  saturating count of passing compares
- pending  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Push: dut_valid writes {order, pc, insn, rd_addr, rd_wdata, trap} at the write pointer. Pointers wrap modulo DEPTH.
- Pop/compare: ref_valid pops the oldest entry and compares it with ref_*.
  - rd_wdata is compared only when the entry's rd_addr ≠ 0.
  - All other fields are always compared.
- Empty FIFO with dut_valid and ref_valid in the same cycle: bypass. Compare dut_* directly with ref_*; nothing is stored and pending stays unchanged.
- Full FIFO with dut_valid and ref_valid: the push is accepted and pending stays DEPTH.
- Full FIFO with dut_valid and no ref_valid: the entry is dropped, overflow is set and pointers do not move.
- Empty FIFO with ref_valid and no dut_valid: underflow is set and no compare is made.
- Compare result:
  - Any field differs: mismatch pulses, mismatch_field and mismatch_order load and hold until the next compare, and error is set.
  - All fields match: match_count increments, saturating at 2^32−1, and mismatch_field clears to 0.
- Comparison continues after an error. Sticky flags clear only on reset.
- State machine (timeout path, see Configuration): IDLE (pending = 0) → WAIT on push. WAIT → IDLE when pending reaches 0. WAIT → STALLED when the stall counter reaches TIMEOUT. STALLED holds until reset; comparisons still proceed.

## Timing
- All outputs are registered.
- Reset values: every output is 0; FIFO pointers and stall counter are 0; state is IDLE.
- Compare latency: mismatch, mismatch_field, mismatch_order and match_count update on the edge after the ref_valid cycle.
- overflow and underflow assert on the edge after the offending cycle.
- pending reflects the push/pop of cycle N on edge N+1.
- Stall counter:
  - Cleared on every ref_valid and whenever pending = 0.
  - Otherwise increments each cycle.
  - timeout asserts on the edge where the count reaches TIMEOUT.
- Asynchronous reset mid-operation empties the FIFO immediately and discards any in-flight compare; no mismatch pulse follows reset release.

## Configuration
- LOCKSTEP_CMP_TIMEOUT_EN defined: stall counter and IDLE/WAIT/STALLED state machine are compiled in; timeout behaves as above.
- LOCKSTEP_CMP_TIMEOUT_EN undefined: counter and state machine are absent, timeout is tied to 0, and error excludes it. All other behaviour is unchanged.

## Test plan
- Three dut retirements (orders 1,2,3) followed two cycles later by three identical ref retirements → match_count = 3, mismatch never pulses, pending 0→3→0.
- Push order 5 with rd_wdata 0x1234; ref retires order 5 with rd_wdata 0x1235 → one mismatch pulse, mismatch_field = 6'b010000, mismatch_order = 5, error = 1.
- rd_addr = 0 on both sides with different rd_wdata → counted as a match, no mismatch.
- DEPTH = 8: nine pushes without ref → overflow = 1 on edge after the 9th and pending = 8. Then a same-cycle push+pop at full → pending stays 8 and no new overflow.
- ref_valid alone on reset-released empty FIFO → underflow = 1, match_count = 0. Same-cycle dut/ref on empty FIFO → bypass match and pending stays 0.
- With LOCKSTEP_CMP_TIMEOUT_EN and TIMEOUT = 16: one push, no ref → timeout = 1 on the 16th cycle after the push edge. Then assert reset_n = 0 mid-stall → all outputs 0 asynchronously.
